// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch port and the memory controller.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined; otherwise both counters read 0.
module icache_direct #(
  parameter int unsigned SETS    = 16,
  parameter logic [31:0] PC_INIT = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, next_state;
  logic [31:0]       miss_addr;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];
  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;
  logic              hit, fill_done;

  // PC_INIT exists only so the instance matches the datapath parameter set.
  logic unused_pc_init;
  assign unused_pc_init = ^PC_INIT;

  assign req_idx   = imemaddr[2 +: IDX_W];
  assign req_tag   = imemaddr[31 : 2+IDX_W];
  assign fill_idx  = miss_addr[2 +: IDX_W];
  assign fill_tag  = miss_addr[31 : 2+IDX_W];
  assign hit       = (state == IDLE) && imemREN && valid[req_idx] &&
                     (tag_mem[req_idx] == req_tag);
  assign fill_done = (state == FILL) && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
    end else begin
      state <= next_state;
      if (state == IDLE && imemREN && !hit)
        miss_addr <= imemaddr;
    end
  end

  // Hits are served combinationally; a fill blocks lookups until it lands.
  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    iREN       = 1'b0;
    iaddr      = imemaddr;
    imemload   = data_mem[req_idx];
    case (state)
      IDLE: begin
        ihit = hit;
        if (imemREN && !hit)
          next_state = FILL;
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait)
          next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      valid <= '0;
    else if (fill_done)
      valid[fill_idx] <= 1'b1;
  end

  // Tag and data need no reset: valid gates every use.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (ihit)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && next_state == FILL)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule
